param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem.sv | 45 ++++
 rtl/param_fifo.sv | 168 ++++++++++++++++
 tb/tb_param_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding and width helper for param_fifo
//   fifo_state_e : 3-bit encoding of the FIFO operation state
//   clog2        : ceiling log2, used for pointer and count widths
package fifo_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101,
        RDWR   = 3'b110
    } fifo_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DATA_W x DEPTH register file with registered read port
//   clk, reset_n      : clock, async active-low reset (clears the read register only)
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr     : synchronous read request
//   rd_data           : registered read data, held when rd_en is low
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage itself is not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Same-edge read/write to one address returns the old contents,
    // which is what a full FIFO doing read+write needs (oldest entry).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parameterised synchronous FIFO with status flags and handshakes
//   clk, reset_n            : clock, async active-low reset
//   wr_en, din              : write request and data
//   rd_en, dout             : read request and registered read data
//   full/empty/almost_*     : flags decoded from the registered entry count
//   wr_ack/wr_err/rd_ack/rd_err : registered per-request outcome, one cycle after the request
//   data_count              : number of stored entries
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     din,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [clog2(DEPTH):0] data_count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

    fifo_state_e   state_q,  state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_err_q, rd_err_d;

    logic          is_full;
    logic          is_empty;
    logic          do_wr;
    logic          do_rd;

    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_rd = rd_en && !is_empty;
    assign do_wr = wr_en && (!is_full || do_rd);

    // Next state depends only on the request and occupancy, so INIT behaves
    // exactly like NO_OP on the first edge after reset release.
    always_comb begin
        state_d  = NO_OP;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case ({wr_en, rd_en})
            2'b10: begin
                if (is_full) begin
                    state_d  = WR_ERR;
                    wr_err_d = 1'b1;
                end else begin
                    state_d  = WRITE;
                    wr_ack_d = 1'b1;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    state_d  = RD_ERR;
                    rd_err_d = 1'b1;
                end else begin
                    state_d  = READ;
                    rd_ack_d = 1'b1;
                end
            end
            2'b11: begin
                if (is_empty) begin
                    state_d  = WRITE;
                    wr_ack_d = 1'b1;
                    rd_err_d = 1'b1;
                end else begin
                    state_d  = RDWR;
                    wr_ack_d = 1'b1;
                    rd_ack_d = 1'b1;
                end
            end
            default: state_d = NO_OP;
        endcase

        // Pointers wrap DEPTH-1 -> 0 by natural overflow (DEPTH is a power of two).
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (do_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_en   (do_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (dout)
    );

    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign wr_ack       = wr_ack_q;
    assign wr_err       = wr_err_q;
    assign rd_ack       = rd_ack_q;
    assign rd_err       = rd_err_q;
    assign data_count   = count_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - scoreboard bench for param_fifo
module tb_param_fifo;
    import fifo_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = DEPTH - 2;
    localparam int AE_LVL = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              wr_en;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
    logic [3:0]        data_count;

    always #5 clk = ~clk;

    param_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_ack       (wr_ack),
        .wr_err       (wr_err),
        .rd_ack       (rd_ack),
        .rd_err       (rd_err),
        .data_count   (data_count)
    );

    typedef struct {
        bit          wa;
        bit          we;
        bit          ra;
        bit          re;
        logic [31:0] dout;
        int          count;
        fifo_state_e st;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_q[$];
    logic [31:0] model_dout;
    int          checks = 0;
    int          errors = 0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus the last word read out.
    task automatic model_step(input bit w, input bit r, input logic [31:0] d);
        exp_t e;
        if (!w && !r) return;
        e.wa = 0; e.we = 0; e.ra = 0; e.re = 0; e.st = NO_OP;
        if (w && r) begin
            if (model_q.size() > 0) begin
                model_dout = model_q.pop_front();
                model_q.push_back(d);
                e.wa = 1; e.ra = 1; e.st = RDWR;
            end else begin
                model_q.push_back(d);
                e.wa = 1; e.re = 1; e.st = WRITE;
            end
        end else if (w) begin
            if (model_q.size() == DEPTH) begin
                e.we = 1; e.st = WR_ERR;
            end else begin
                model_q.push_back(d);
                e.wa = 1; e.st = WRITE;
            end
        end else begin
            if (model_q.size() == 0) begin
                e.re = 1; e.st = RD_ERR;
            end else begin
                model_dout = model_q.pop_front();
                e.ra = 1; e.st = READ;
            end
        end
        e.dout  = model_dout;
        e.count = model_q.size();
        exp_q.push_back(e);
    endtask

    // Drive one request for one edge; returns after the response is visible.
    task automatic issue(input bit w, input bit r, input logic [31:0] d);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        model_step(w, r, d);
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"},  data_count, 0);
        chk({tag, "_empty"},  empty, 1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_full"},   full, 0);
        chk({tag, "_afull"},  almost_full, 0);
        chk({tag, "_hs"},     {wr_ack, wr_err, rd_ack, rd_err}, 0);
        chk({tag, "_dout"},   dout, 0);
        chk({tag, "_state"},  dut.state_q, INIT);
    endtask

    // Monitor: compare against the scoreboard whenever a response is due or shown.
    always begin
        @(posedge clk);
        #1;
        if (reset_n && (exp_q.size() > 0 || wr_ack || wr_err || rd_ack || rd_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: hs=%b expected none", {wr_ack, wr_err, rd_ack, rd_err});
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_ack", wr_ack, mon_e.wa);
                chk("wr_err", wr_err, mon_e.we);
                chk("rd_ack", rd_ack, mon_e.ra);
                chk("rd_err", rd_err, mon_e.re);
                chk("dout", dout, mon_e.dout);
                chk("data_count", data_count, mon_e.count);
                chk("full", full, mon_e.count == DEPTH);
                chk("empty", empty, mon_e.count == 0);
                chk("almost_full", almost_full, mon_e.count >= AF_LVL);
                chk("almost_empty", almost_empty, mon_e.count <= AE_LVL);
                chk("state", dut.state_q, mon_e.st);
            end
        end
    end

    initial begin
        int pw;
        reset_n    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        din        = '0;
        model_dout = '0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("init_hold", dut.state_q, INIT);
        issue(0, 0, 0);
        chk("idle_state", dut.state_q, NO_OP);

        // Fill to full, then overflow.
        for (int i = 0; i < 8; i++) begin
            issue(1, 0, (i + 1) * 32'h11);
            if (i == 4) chk("af_at_5", almost_full, 0);
            if (i == 5) chk("af_at_6", almost_full, 1);
            if (i == 6) chk("full_at_7", full, 0);
        end
        chk("full_at_8", full, 1);
        issue(1, 0, 32'h99);
        chk("overflow_err", wr_err, 1);
        chk("overflow_count", data_count, 8);

        // Drain in order, then underflow.
        for (int i = 0; i < 8; i++) begin
            issue(0, 1, 0);
            chk("drain_dout", dout, (i + 1) * 32'h11);
            if (i == 4) chk("ae_at_3", almost_empty, 0);
            if (i == 5) chk("ae_at_2", almost_empty, 1);
        end
        chk("empty_at_0", empty, 1);
        issue(0, 1, 0);
        chk("underflow_err", rd_err, 1);
        chk("underflow_dout", dout, 32'h88);

        // Simultaneous read/write while full.
        for (int i = 0; i < 8; i++) issue(1, 0, 32'hA0 + i);
        issue(1, 1, 32'hB0);
        chk("rdwr_state", dut.state_q, RDWR);
        chk("rdwr_dout", dout, 32'hA0);
        chk("rdwr_count", data_count, 8);
        chk("rdwr_acks", {wr_ack, rd_ack}, 2'b11);
        for (int i = 0; i < 8; i++) issue(0, 1, 0);

        // Simultaneous read/write while empty.
        issue(1, 1, 32'hC0);
        chk("rw_empty_hs", {wr_ack, wr_err, rd_ack, rd_err}, 4'b1001);
        chk("rw_empty_count", data_count, 1);
        issue(0, 1, 0);
        chk("rw_empty_dout", dout, 32'hC0);

        // Pointer wrap.
        for (int i = 0; i < 20; i++) begin
            issue(1, 0, 32'h100 + i);
            issue(0, 1, 0);
            chk("wrap_dout", dout, 32'h100 + i);
        end

        // Asynchronous reset between edges with 5 entries stored.
        for (int i = 0; i < 5; i++) issue(1, 0, 32'h200 + i);
        chk("pre_reset_count", data_count, 5);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_q.delete();
        exp_q.delete();
        model_dout = '0;
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        chk("post_release_init", dut.state_q, INIT);
        issue(1, 0, 32'hD0);
        chk("first_edge_write", dut.state_q, WRITE);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int c = 0; c < 400; c++) begin
            pw = ((c / 50) % 2 == 0) ? 75 : 30;
            issue($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), $urandom);
        end

        issue(0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
